// File: rtl/complex_divider.sv
// Iterative signed complex divider (A1 + jA2) / (B1 + jB2): one shared restoring core, real then imaginary quotient.
// Optional build macro CDIV_ROUND_EN selects round-to-nearest (ties away from zero) instead of truncation.
module complex_divider #(
    parameter int NUMBER_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Start,
    input  logic signed [NUMBER_SIZE-1:0] A1,
    input  logic signed [NUMBER_SIZE-1:0] A2,
    input  logic signed [NUMBER_SIZE-1:0] B1,
    input  logic signed [NUMBER_SIZE-1:0] B2,
    output logic                          Busy,
    output logic                          Done,
    output logic signed [NUMBER_SIZE-1:0] Out1,
    output logic signed [NUMBER_SIZE-1:0] Out2,
    output logic                          DivZero,
    output logic                          Sat
);
    localparam int N     = NUMBER_SIZE;
    localparam int DIV_W = 2 * N;
    localparam int CW    = $clog2(DIV_W);
    localparam logic [DIV_W:0] MAX_POS = (DIV_W+1)'(2 ** (N - 1) - 1);
    localparam logic [DIV_W:0] MAX_NEG = (DIV_W+1)'(2 ** (N - 1));

    typedef enum logic [1:0] {IDLE, PREP, DIV_RE, DIV_IM} state_t;
    state_t state, state_next;

    logic signed [N-1:0]     a1_q, a2_q, b1_q, b2_q;
    logic signed [DIV_W:0]   nr_full, ni_full, d_full;
    logic [DIV_W-1:0]        nr_mag, ni_mag, ni_mag_q, d_q, num, rem;
    logic [DIV_W:0]          rem_shift, re_mag, mag_final;
    logic [DIV_W-1:0]        rem_step, q_step;
    logic                    fits, last, re_neg, im_neg;
    logic [CW-1:0]           cnt;
    logic [N:0]              re_res, im_res;

    // Full-precision numerators and denominator from the operands latched at accept.
    always_comb begin
        nr_full = a1_q * b1_q + a2_q * b2_q;
        ni_full = a2_q * b1_q - a1_q * b2_q;
        d_full  = b1_q * b1_q + b2_q * b2_q;
        nr_mag  = nr_full[DIV_W] ? DIV_W'(-nr_full) : DIV_W'(nr_full);
        ni_mag  = ni_full[DIV_W] ? DIV_W'(-ni_full) : DIV_W'(ni_full);
    end

    // One restoring step; num shifts out dividend bits MSB first and shifts in quotient bits.
    always_comb begin
        rem_shift = {rem, num[DIV_W-1]};
        fits      = rem_shift >= {1'b0, d_q};
        rem_step  = fits ? DIV_W'(rem_shift - {1'b0, d_q}) : rem_shift[DIV_W-1:0];
        q_step    = {num[DIV_W-2:0], fits};
        mag_final = {1'b0, q_step};
`ifdef CDIV_ROUND_EN
        if ({rem_step, 1'b0} >= {1'b0, d_q})
            mag_final = mag_final + (DIV_W+1)'(1);
`endif
        last = (cnt == CW'(DIV_W - 1));
    end

    // Returns {clipped, signed result}.
    function automatic logic [N:0] saturate(input logic neg, input logic [DIV_W:0] mag);
        if (!neg)
            return (mag > MAX_POS) ? {1'b1, 1'b0, {(N-1){1'b1}}} : {1'b0, mag[N-1:0]};
        else
            return (mag > MAX_NEG) ? {1'b1, 1'b1, {(N-1){1'b0}}} : {1'b0, ~mag[N-1:0] + 1'b1};
    endfunction

    always_comb begin
        re_res = saturate(re_neg, re_mag);
        im_res = saturate(im_neg, mag_final);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = PREP;
            PREP:    state_next = (d_full == '0) ? IDLE : DIV_RE;
            DIV_RE:  if (last) state_next = DIV_IM;
            DIV_IM:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q <= '0; a2_q <= '0; b1_q <= '0; b2_q <= '0;
            ni_mag_q <= '0; d_q <= '0; num <= '0; rem <= '0; cnt <= '0;
            re_mag <= '0; re_neg <= 1'b0; im_neg <= 1'b0;
            Done <= 1'b0; Out1 <= '0; Out2 <= '0; DivZero <= 1'b0; Sat <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    a1_q <= A1; a2_q <= A2; b1_q <= B1; b2_q <= B2;
                end
                PREP: begin
                    re_neg   <= nr_full[DIV_W];
                    im_neg   <= ni_full[DIV_W];
                    num      <= nr_mag;
                    ni_mag_q <= ni_mag;
                    d_q      <= d_full[DIV_W-1:0];
                    rem      <= '0;
                    cnt      <= '0;
                    if (d_full == '0) begin
                        Out1 <= '0; Out2 <= '0; DivZero <= 1'b1; Sat <= 1'b0; Done <= 1'b1;
                    end
                end
                DIV_RE: begin
                    rem <= rem_step;
                    num <= q_step;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        re_mag <= mag_final;
                        num    <= ni_mag_q;
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                DIV_IM: begin
                    rem <= rem_step;
                    num <= q_step;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        Out1    <= re_res[N-1:0];
                        Out2    <= im_res[N-1:0];
                        Sat     <= re_res[N] | im_res[N];
                        DivZero <= 1'b0;
                        Done    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_divider.sv
// Scoreboard bench for complex_divider: accepts push expected results, a monitor pops them on Done.
module tb_complex_divider;
    localparam int W = 18;  // {out1[7:0], out2[7:0], divzero, sat}
`ifdef CDIV_ROUND_EN
    localparam int Q_P7 = 4;
    localparam int Q_M7 = -4;
`else
    localparam int Q_P7 = 3;
    localparam int Q_M7 = -3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Start = 1'b0;
    logic signed [7:0] A1 = '0, A2 = '0, B1 = '0, B2 = '0;
    logic Busy, Done, DivZero, Sat;
    logic signed [7:0] Out1, Out2;

    logic [W-1:0] exp_q[$];
    int acc_q[$];
    logic [W-1:0] pend = '0;
    logic pend_v = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    complex_divider dut (
        .clk(clk), .rst_n(rst_n), .Start(Start),
        .A1(A1), .A2(A2), .B1(B1), .B2(B2),
        .Busy(Busy), .Done(Done), .Out1(Out1), .Out2(Out2),
        .DivZero(DivZero), .Sat(Sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int quot(input int n, input int d);
        int q;
        q = n / d;
`ifdef CDIV_ROUND_EN
        begin
            int r;
            r = n % d;
            if (2 * ((r < 0) ? -r : r) >= d) q += (n < 0) ? -1 : 1;
        end
`endif
        return q;
    endfunction

    function automatic logic [W-1:0] model(input int a1, input int a2, input int b1, input int b2);
        int nr, ni, d, qr, qi;
        logic s;
        nr = a1 * b1 + a2 * b2;
        ni = a2 * b1 - a1 * b2;
        d  = b1 * b1 + b2 * b2;
        if (d == 0) return {8'd0, 8'd0, 1'b1, 1'b0};
        qr = quot(nr, d);
        qi = quot(ni, d);
        s  = (qr > 127) || (qr < -128) || (qi > 127) || (qi < -128);
        if (qr > 127) qr = 127; else if (qr < -128) qr = -128;
        if (qi > 127) qi = 127; else if (qi < -128) qi = -128;
        return {8'(qr), 8'(qi), 1'b0, s};
    endfunction

    // Accept watcher: inputs change only just after posedge, so this sees what the next edge samples.
    always @(negedge clk) begin
        if (rst_n && Start && !Busy) begin
            exp_q.push_back(pend_v ? pend : model(A1, A2, B1, B2));
            acc_q.push_back(cyc + 1);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n && Done) begin
            logic [W-1:0] e;
            int a;
            done_cnt++;
            chk("busy_with_done", int'(Busy), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("out1", int'(Out1), int'($signed(e[17:10])));
                chk("out2", int'(Out2), int'($signed(e[9:2])));
                chk("divzero", int'(DivZero), int'(e[1]));
                chk("sat", int'(Sat), int'(e[0]));
                chk("latency", cyc - a, e[1] ? 1 : 33);
            end
        end
    end

    task automatic issue_start(input int a1, input int a2, input int b1, input int b2,
                               input int e1, input int e2, input logic dz, input logic st);
        @(posedge clk); #1;
        A1 = 8'(a1); A2 = 8'(a2); B1 = 8'(b1); B2 = 8'(b2);
        pend = {8'(e1), 8'(e2), dz, st};
        pend_v = 1'b1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        pend_v = 1'b0;
        A1 = 8'($urandom_range(0, 255)); A2 = 8'($urandom_range(0, 255));
        B1 = 8'($urandom_range(0, 255)); B2 = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!Busy && exp_q.size() == 0) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic issue(input int a1, input int a2, input int b1, input int b2,
                         input int e1, input int e2, input logic dz, input logic st);
        issue_start(a1, a2, b1, b2, e1, e2, dz, st);
        wait_idle();
    endtask

    initial begin
        int d0;
        #3;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_out1", int'(Out1), 0);
        chk("rst_out2", int'(Out2), 0);
        chk("rst_divzero", int'(DivZero), 0);
        chk("rst_sat", int'(Sat), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(100, 100, 1, 1, 100, 0, 1'b0, 1'b0);
        issue(100, 100, 1, -1, 0, 100, 1'b0, 1'b0);
        issue(-7, 0, 2, 0, Q_M7, 0, 1'b0, 1'b0);
        issue(7, 0, 2, 0, Q_P7, 0, 1'b0, 1'b0);
        issue(-128, 0, -1, 0, 127, 0, 1'b0, 1'b1);
        issue(5, 3, 0, 0, 0, 0, 1'b1, 1'b0);
        issue(3, 4, 1, 2, 2, 0, 1'b0, 1'b0);
        issue(127, 127, 0, 1, 127, -127, 1'b0, 1'b0);
        issue(-128, -128, 0, -1, 127, -128, 1'b0, 1'b1);
        issue(1, 0, 16, 0, 0, 0, 1'b0, 1'b0);
        issue(100, 0, 3, 0, 33, 0, 1'b0, 1'b0);

        // Reset in the middle of the real-part division: aborts without Done.
        issue_start(100, 100, 1, 1, 100, 0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_done", int'(Done), 0);
        chk("midrst_out1", int'(Out1), 0);
        chk("midrst_out2", int'(Out2), 0);
        exp_q.delete();
        acc_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        issue(100, 100, 1, -1, 0, 100, 1'b0, 1'b0);

        // Start pulse while busy is ignored.
        issue_start(-7, 0, 2, 0, Q_M7, 0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        A1 = 8'sd50; A2 = 8'sd0; B1 = 8'sd1; B2 = 8'sd0;
        Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
        wait_idle();

        // Start held with operands changing every cycle: back-to-back accepts only.
        d0 = done_cnt;
        @(posedge clk); #1;
        Start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            A1 = 8'($urandom_range(0, 255)); A2 = 8'($urandom_range(0, 255));
            B1 = 8'($urandom_range(0, 255)); B2 = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        Start = 1'b0;
        wait_idle();
        chk("held_start_ops", done_cnt - d0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
